// File: rtl/m_axi_reg_pkg.sv
// Shared types and AXI response codes for the single-beat AXI register master.
package m_axi_reg_pkg;

  localparam int unsigned ID_WIDTH = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/axi_watchdog.sv
// Per-transaction cycle counter; saturates at LIMIT and flags expiry. LIMIT = 0 disables it.
module axi_watchdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic areset,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  assign expired_o = (LIMIT != 0) && (cnt == CNT_W'(LIMIT));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (run_i && !expired_o) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/m_axi_reg_master.sv
// Single-beat AXI4 initiator: command/response stream in, AXI AW/W/B and AR/R out, with watchdog.
module m_axi_reg_master
  import m_axi_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ID_WIDTH-1:0]     cmd_id_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic                    rsp_timeout_o,
  output logic [ID_WIDTH-1:0]     rsp_id_o,
  output logic [ID_WIDTH-1:0]     awid_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ID_WIDTH-1:0]     wid_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_WIDTH-1:0]     bid_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [ID_WIDTH-1:0]     arid_o,
  output logic [ADDR_WIDTH-1:0]   araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [ID_WIDTH-1:0]     rid_i,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic                    rlast_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  cmd_hs, expired, fire_to, wd_run;
  logic                  awv_d, wv_d, arv_d, tmo_d;
  logic [1:0]            resp_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  assign cmd_ready_o = (state_q == IDLE);
  assign cmd_hs      = cmd_ready_o && cmd_valid_i;
  assign wd_run      = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_RESP);

  axi_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .areset   (areset),
    .clear_i  (cmd_hs),
    .run_i    (wd_run),
    .expired_o(expired)
  );

  // Next state plus next values of the registered channel/response outputs.
  always_comb begin
    state_d = state_q;
    awv_d   = awvalid_o;
    wv_d    = wvalid_o;
    arv_d   = arvalid_o;
    resp_d  = rsp_resp_o;
    rdata_d = rsp_rdata_o;
    tmo_d   = rsp_timeout_o;
    fire_to = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = cmd_write_i ? WR_REQ : RD_REQ;
          awv_d   = cmd_write_i;
          wv_d    = cmd_write_i;
          arv_d   = !cmd_write_i;
        end
      end
      WR_REQ: begin
        awv_d = awvalid_o && !awready_i;
        wv_d  = wvalid_o && !wready_i;
        if (!awv_d && !wv_d) state_d = WR_RESP;
        else                 fire_to = expired;
      end
      WR_RESP: begin
        if (bvalid_i) begin
          state_d = DONE;
          resp_d  = (bid_i == id_q) ? bresp_i : RESP_SLVERR;
          rdata_d = '0;
          tmo_d   = 1'b0;
        end else begin
          fire_to = expired;
        end
      end
      RD_REQ: begin
        arv_d = arvalid_o && !arready_i;
        if (!arv_d) state_d = RD_RESP;
        else        fire_to = expired;
      end
      RD_RESP: begin
        if (rvalid_i) begin
          state_d = DONE;
          rdata_d = rdata_i;
          resp_d  = (rid_i == id_q && rlast_i) ? RESP_OKAY : RESP_SLVERR;
          tmo_d   = 1'b0;
        end else begin
          fire_to = expired;
        end
      end
      DONE: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Channel events above take priority; only a stalled phase times out.
    if (fire_to) begin
      state_d = DONE;
      resp_d  = RESP_DECERR;
      rdata_d = '0;
      tmo_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      id_q          <= '0;
      awid_o        <= '0;
      awaddr_o      <= '0;
      awvalid_o     <= 1'b0;
      wid_o         <= '0;
      wdata_o       <= '0;
      wstrb_o       <= '0;
      wlast_o       <= 1'b0;
      wvalid_o      <= 1'b0;
      bready_o      <= 1'b0;
      arid_o        <= '0;
      araddr_o      <= '0;
      arvalid_o     <= 1'b0;
      rready_o      <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_resp_o    <= '0;
      rsp_timeout_o <= 1'b0;
      rsp_id_o      <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_o     <= awv_d && (state_d == WR_REQ);
      wvalid_o      <= wv_d && (state_d == WR_REQ);
      wlast_o       <= wv_d && (state_d == WR_REQ);
      arvalid_o     <= arv_d && (state_d == RD_REQ);
      bready_o      <= (state_d == WR_RESP);
      rready_o      <= (state_d == RD_RESP);
      rsp_valid_o   <= (state_d == DONE);
      rsp_resp_o    <= resp_d;
      rsp_rdata_o   <= rdata_d;
      rsp_timeout_o <= tmo_d;
      if (cmd_hs) begin
        id_q     <= cmd_id_i;
        rsp_id_o <= cmd_id_i;
        awid_o   <= cmd_id_i;
        wid_o    <= cmd_id_i;
        arid_o   <= cmd_id_i;
        awaddr_o <= cmd_addr_i;
        araddr_o <= cmd_addr_i;
        wdata_o  <= cmd_wdata_i;
        wstrb_o  <= cmd_wstrb_i;
      end
    end
  end

endmodule

// File: tb/tb_m_axi_reg_master.sv
// Directed self-checking bench for m_axi_reg_master against a level-driven AXI slave model.
module tb_m_axi_reg_master;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_id = '0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_id;
  logic [3:0]  awid, wid, arid, bid = '0, rid = '0;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b1, wlast, wvalid, wready = 1'b1;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b1, bready, arvalid, arready = 1'b1;
  logic        rlast = 1'b1, rvalid = 1'b1, rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_axi_reg_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .areset(areset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_id_i(cmd_id), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout), .rsp_id_o(rsp_id),
    .awid_o(awid), .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
    .wid_o(wid), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid),
    .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .arid_o(arid), .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the handshake.
  task automatic issue(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_arrive", rsp_valid, 1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  int cyc;
  int seen;
  logic [31:0] hold_rdata;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_awvalid", awvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    areset = 1'b0;
    @(negedge clk);

    // Zero-wait write
    bid = 4'd3; bresp = 2'b00; bvalid = 1'b1;
    issue(1'b1, 4'd3, 32'd3, 32'hDEADBEEF, 4'hF);
    check("w1_awvalid", awvalid, 1);
    check("w1_wvalid", wvalid, 1);
    check("w1_wlast", wlast, 1);
    check("w1_awaddr", awaddr, 32'd3);
    check("w1_wdata", wdata, 32'hDEADBEEF);
    check("w1_wstrb", wstrb, 4'hF);
    check("w1_awid", awid, 4'd3);
    check("w1_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    check("w1_aw_drop", awvalid, 0);
    check("w1_bready", bready, 1);
    check("w1_rsp_early", rsp_valid, 0);
    @(negedge clk);
    check("w1_rsp_valid", rsp_valid, 1);
    check("w1_resp", rsp_resp, 2'b00);
    check("w1_rdata", rsp_rdata, 0);
    check("w1_id", rsp_id, 4'd3);
    check("w1_timeout", rsp_timeout, 0);
    check("w1_bready_drop", bready, 0);
    finish_rsp();

    // Write with wready delayed 5 cycles after the AW handshake
    bid = 4'd5; wready = 1'b0;
    issue(1'b1, 4'd5, 32'h10, 32'h0000_00A5, 4'h1);
    check("w2_awvalid", awvalid, 1);
    check("w2_wvalid", wvalid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("w2_aw_dropped", awvalid, 0);
      check("w2_w_held", wvalid, 1);
      check("w2_no_bready", bready, 0);
    end
    wready = 1'b1;
    @(negedge clk);
    check("w2_w_drop", wvalid, 0);
    check("w2_bready", bready, 1);
    @(negedge clk);
    check("w2_bready_pulse", bready, 0);
    check("w2_rsp_valid", rsp_valid, 1);
    check("w2_resp", rsp_resp, 2'b00);
    finish_rsp();

    // Read, matching rid
    rdata = 32'h12345678; rid = 4'd7; rlast = 1'b1; rvalid = 1'b1;
    issue(1'b0, 4'd7, 32'd2, 32'd0, 4'h0);
    check("r1_arvalid", arvalid, 1);
    check("r1_araddr", araddr, 32'd2);
    check("r1_no_awvalid", awvalid, 0);
    @(negedge clk);
    check("r1_ar_drop", arvalid, 0);
    check("r1_rready", rready, 1);
    @(negedge clk);
    check("r1_rsp_valid", rsp_valid, 1);
    check("r1_rdata", rsp_rdata, 32'h12345678);
    check("r1_resp", rsp_resp, 2'b00);
    check("r1_id", rsp_id, 4'd7);
    finish_rsp();

    // Read, mismatched rid
    rid = 4'd4;
    issue(1'b0, 4'd7, 32'd2, 32'd0, 4'h0);
    wait_rsp(10, cyc);
    check("r2_resp", rsp_resp, 2'b10);
    check("r2_rdata", rsp_rdata, 32'h12345678);
    finish_rsp();

    // Read with rlast low
    rid = 4'd6; rlast = 1'b0;
    issue(1'b0, 4'd6, 32'd8, 32'd0, 4'h0);
    wait_rsp(10, cyc);
    check("r3_resp", rsp_resp, 2'b10);
    finish_rsp();
    rlast = 1'b1;

    // Watchdog: slave never answers B
    bvalid = 1'b0; bid = 4'd1;
    issue(1'b1, 4'd1, 32'h20, 32'h1, 4'hF);
    wait_rsp(40, cyc);
    check("to_not_early", (cyc >= 8) ? 1 : 0, 1);
    check("to_resp", rsp_resp, 2'b11);
    check("to_flag", rsp_timeout, 1);
    check("to_rdata", rsp_rdata, 0);
    check("to_bready", bready, 0);
    check("to_awvalid", awvalid, 0);
    finish_rsp();
    bvalid = 1'b1; bid = 4'd2;
    issue(1'b1, 4'd2, 32'h24, 32'h2, 4'hF);
    wait_rsp(10, cyc);
    check("to_next_resp", rsp_resp, 2'b00);
    check("to_next_flag", rsp_timeout, 0);
    check("to_next_id", rsp_id, 4'd2);
    finish_rsp();

    // Response backpressure
    rdata = 32'hCAFE0001; rid = 4'd9;
    issue(1'b0, 4'd9, 32'h30, 32'd0, 4'h0);
    wait_rsp(10, cyc);
    hold_rdata = rsp_rdata;
    check("bp_rdata", hold_rdata, 32'hCAFE0001);
    rdata = 32'h0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata_stable", rsp_rdata, 32'hCAFE0001);
      check("bp_id_stable", rsp_id, 4'd9);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    finish_rsp();

    // Reset during RD_RESP abandons the transaction
    rvalid = 1'b0; rid = 4'd9;
    issue(1'b0, 4'd9, 32'h40, 32'd0, 4'h0);
    @(negedge clk);
    check("rst_mid_rready_pre", rready, 1);
    #1 areset = 1'b1;
    #1;
    check("rst_mid_arvalid", arvalid, 0);
    check("rst_mid_rready", rready, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    areset = 1'b0;
    rvalid = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid || rready) seen++;
    end
    check("rst_mid_no_rsp", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_axi_reg_master.md
# m_axi_reg_master

Single-beat AXI4 initiator that turns a simple command/response stream into AXI register writes and reads. It is the master-side counterpart of the team's AXI register slaves. It drives their AW/W/B and AR/R channels, with IDs, WSTRB, and WLAST fixed for single beats. Targets are test sequencers, CPU-less bring-up logic, and bench drivers that need a bounded-latency register port with a watchdog.

## Interface
- DATA_WIDTH, 32, data bus width (WSTRB is DATA_WIDTH/8 = 4 bits)
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 256, watchdog limit in cycles per transaction; 0 disables the watchdog
- clk  in  1  single clock, rising edge
- areset  in  1  reset; asynchronous, active-high
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_id_i  in  4  transaction ID
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i / cmd_wstrb_i  in  DATA_WIDTH / 4  write data and byte strobes
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp_o  out  2  AXI response code
- rsp_timeout_o  out  1  watchdog fired
- rsp_id_o  out  4  ID of the completed command
- awid_o, awaddr_o, awvalid_o / awready_i  write address channel
- wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o / wready_i  write data channel
- bid_i, bresp_i(2), bvalid_i / bready_o  write response channel
- arid_o, araddr_o, arvalid_o / arready_i  read address channel
- rid_i, rdata_i, rlast_i, rvalid_i / rready_o  read data channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE
  - cmd_ready_o = 1 only in IDLE.
  - On the cmd handshake, latch id/addr/wdata/wstrb and clear the watchdog.
  - Go to WR_REQ or RD_REQ.
- WR_REQ
  - awvalid_o and wvalid_o both assert; wlast_o = 1 whenever wvalid_o = 1.
  - Each valid drops independently after its own handshake; the two channels may complete in either order or in the same cycle.
  - Leave WR_REQ when both have completed.
- WR_RESP
  - bready_o = 1.
  - On bvalid_i, capture bresp_i into rsp_resp_o.
  - If bid_i differs from the latched ID, report 2'b10 (SLVERR) instead.
  - Go to DONE.
- RD_REQ
  - arvalid_o = 1 until arready_i.
- RD_RESP
  - rready_o = 1.
  - On rvalid_i, capture rdata_i and set rsp_resp_o = 2'b00.
  - Report 2'b10 if rid_i mismatches the latched ID or rlast_i = 0.
  - Go to DONE.
- DONE
  - rsp_valid_o = 1 until rsp_ready_i, then return to IDLE.
- Watchdog
  - Counts every cycle spent in WR_REQ, WR_RESP, RD_REQ, and RD_RESP.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - When the count equals TIMEOUT_CYCLES, all AXI valid/ready outputs drop in the next cycle.
  - It then enters DONE with rsp_resp_o = 2'b11, rsp_timeout_o = 1, and rsp_rdata_o = 0.
  - If a channel event and the timeout occur in the same cycle, the channel event wins.
- Reset
  - All AXI outputs and rsp_* go to 0, the state returns to IDLE, and cmd_ready_o = 1.
  - Reset mid-transaction abandons the transaction; no response is produced.

## Timing
- All AXI and rsp outputs are registered; cmd_ready_o is decoded from the state.
- Command handshake at cycle N gives awvalid_o/wvalid_o (or arvalid_o) = 1 at N+1.
- With zero-wait-state slaves, rsp_valid_o rises at N+3 for both reads and writes.
- bready_o/rready_o assert on the cycle after the last address or data handshake; a B or R beat arriving earlier is not accepted.
- Back-to-back throughput: the next cmd is accepted in the cycle after the rsp handshake, at earliest N+4.
- While rsp_valid_o = 1, all rsp fields are stable.

## Structure
- Package m_axi_reg_pkg holds:
  - the state enum typedef;
  - constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
- Sub-module axi_watchdog (parameter LIMIT; ports clk, areset, clear_i, run_i, expired_o) holds the watchdog counter.
- The FSM and channel flags stay in the top module.

## Test plan
- Write 0xDEADBEEF to addr 3, strb 4'hF, slave zero-wait, bresp 00 → AW/W valid at N+1, rsp_valid at N+3, resp 00, rdata 0.
- Write with wready delayed 5 cycles after awready → awvalid drops after its own handshake, wvalid is held, single bready pulse, resp 00.
- Read addr 2, slave returns rdata 0x12345678, rid matching, rlast = 1 → rsp_rdata 0x12345678, resp 00; repeat with rid mismatched → resp 10.
- Slave never asserts bvalid, TIMEOUT_CYCLES = 8 → rsp_valid with resp 11, timeout 1; the next command then completes normally.
- rsp_ready held low 10 cycles → rsp fields stable, cmd_ready_o stays 0 until the rsp handshake.
- areset pulsed while in RD_RESP → arvalid/rready/rsp_valid go 0 immediately, cmd_ready_o = 1, no response is emitted afterwards.
